// File: rtl/led_arbiter.sv
// led_arbiter: round-robin owner selection for the board's single active-low RGB LED.
// Each grant lasts at least HOLD cycles while others wait, and an all-off cycle separates owners.
// Optional feature macro: LED_ARB_PRIO_EN (requester 0 pre-empts and always wins in IDLE).
// Ports:
//   clk           system clock
//   rst           asynchronous active-high reset
//   req[NREQ]     level request per requester
//   rgb[3*NREQ]   requester i colour at rgb[3i+2:3i] = {r,g,b}, 1 = on
//   gnt[NREQ]     registered one-hot grant
//   busy          high while a grant is active
//   led_r/g/b     registered LED drive, active-low
module led_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned HOLD = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [3*NREQ-1:0] rgb,
  output logic [NREQ-1:0]   gnt,
  output logic              busy,
  output logic              led_r,
  output logic              led_g,
  output logic              led_b
);

  localparam int unsigned PW = $clog2(NREQ);
  localparam int unsigned CW = $clog2(HOLD + 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            busy_q, busy_d;
  logic [2:0]      led_q, led_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   own_q, own_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            win_found;
  logic [PW-1:0]   win_idx;
  logic [2:0]      win_rgb;
  logic [2:0]      own_rgb;
  logic            own_req;
  logic            others_req;
  logic            release_c;

  // First requester at or after ptr, wrapping at NREQ.
  always_comb begin : p_scan
    int unsigned idx;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!win_found && req[PW'(idx)]) begin
        win_found = 1'b1;
        win_idx   = PW'(idx);
      end
    end
`ifdef LED_ARB_PRIO_EN
    if (req[0]) begin
      win_found = 1'b1;
      win_idx   = '0;
    end
`endif
  end

  // Per-index muxes for the winner's and owner's colour and the owner's request.
  always_comb begin
    win_rgb = '0;
    own_rgb = '0;
    own_req = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win_idx == PW'(i)) win_rgb = rgb[3*i +: 3];
      if (own_q == PW'(i)) begin
        own_rgb = rgb[3*i +: 3];
        own_req = req[i];
      end
    end
  end

  // gnt_q is one-hot on the owner during GRANT, so masking it leaves the waiters.
  assign others_req = |(req & ~gnt_q);

  always_comb begin
    release_c = !own_req || ((cnt_q == '0) && others_req);
`ifdef LED_ARB_PRIO_EN
    if ((own_q != '0) && req[0]) release_c = 1'b1;
`endif
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    busy_d  = busy_q;
    led_d   = led_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        gnt_d  = '0;
        busy_d = 1'b0;
        led_d  = 3'b111;
        if (win_found) begin
          state_d = S_GRANT;
          gnt_d   = NREQ'(1) << win_idx;
          busy_d  = 1'b1;
          cnt_d   = CW'(HOLD - 1);
          led_d   = ~win_rgb;
          own_d   = win_idx;
        end
      end
      S_GRANT: begin
        if (release_c) begin
          state_d = S_IDLE;
          gnt_d   = '0;
          busy_d  = 1'b0;
          led_d   = 3'b111;
          ptr_d   = (own_q == PW'(NREQ - 1)) ? '0 : own_q + PW'(1);
        end else begin
          led_d = ~own_rgb;
          if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      led_q   <= 3'b111;
      ptr_q   <= '0;
      own_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      led_q   <= led_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt   = gnt_q;
  assign busy  = busy_q;
  assign led_r = led_q[2];
  assign led_g = led_q[1];
  assign led_b = led_q[0];

endmodule
